ft64_ins_aligner: RTL and testbench
===================================

Name: ft64_ins_aligner

Overview:
- Multi-lane instruction aligner between the I-cache fetch port and the FT64 decoder.
- Buffers raw fetch bytes and computes each variable-length instruction's length from its first byte.
- Presents up to LANES aligned instructions per cycle, each with its PC.
- Generalises single-instruction length decode to a buffered, multi-lane, flushable stream.

Parameters:
- FETCH_BYTES, 16, bytes delivered per accepted fetch beat.
- BUF_BYTES, 32, byte-buffer capacity; must be >= FETCH_BYTES+7.
- LANES, 2, maximum instructions presented per cycle (1..4).
- PCW, 32, PC width.
- CMPRSSD_OP, 6'h2D, opcode (byte0[5:0]) of the compressed-instruction format; used only with the optional feature.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset, synchronous, active-low.
- pred_on  in  1  predicate byte present; ORs 1 into every length.
- flush  in  1  discard buffer and restart at flush_pc.
- flush_pc  in  PCW  new fetch PC on flush.
- fetch_valid  in  1  fetch beat offered.
- fetch_data  in  FETCH_BYTES*8  fetch bytes; byte 0 in [7:0].
- fetch_ready  out  1  beat will be accepted.
- ins_valid  out  LANES  lane k holds a complete instruction; thermometer (lane k valid implies lanes <k valid).
- ins  out  LANES*56  lane k at [56k+55:56k]; bytes beyond its length are zero.
- ins_len  out  LANES*3  length of lane k in bytes.
- ins_pc  out  LANES*PCW  PC of lane k.
- dec_ready  in  1  decoder consumes all valid lanes this cycle.

Behaviour:
- Length rule per instruction, taken from its first byte b:
  - b[7:6]=00 -> 4
  - b[7:6]=01 -> 6
  - b[7:6]=10 or 11 -> 2
  - Result ORed with pred_on, giving 5/7/3.
- State:
  - byte buffer buf[0..BUF_BYTES-1], head at buf[0].
  - count, range 0..BUF_BYTES.
  - head_pc.
- Lane offsets: off0=0; offk = off(k-1) + len(k-1).
- Lane k is valid iff ins_valid[k-1] (k>0) and count >= offk+lenk. Lengths of invalid lanes are still computed but don't-care.
- Outputs are combinational from registered state: zero cycles from buffer to lanes, one cycle from an accepted fetch to visibility.
- ins_pc[k] = head_pc + offk, mod 2^PCW.
- Consume: when dec_ready and ins_valid[0], take = sum of valid lane lengths.
  - Buffer shifts down by take; head_pc += take; count -= take.
  - dec_ready with ins_valid[0]=0 has no effect.
- fetch_ready = rst_n & (count + FETCH_BYTES <= BUF_BYTES), evaluated on registered count. Simultaneous consume does not raise it the same cycle.
- Accept: on fetch_valid & fetch_ready, fetch bytes are written at index count-take.
  - count_next = count - take + FETCH_BYTES.
  - Consume and accept in the same cycle are both honoured.
- Flush has priority over consume and accept:
  - next cycle count=0, head_pc=flush_pc, all ins_valid=0.
  - fetch_ready is deasserted for the flush cycle.
- Partial instruction at buffer end: the lane is held invalid until enough bytes arrive; no bytes are dropped.
- Full buffer with no consume: fetch_ready=0, state holds.
- Reset (rst_n=0 at clk edge), applied even mid-stream:
  - count=0, head_pc=0, buffer zeroed.
  - ins_valid=0, fetch_ready=0; ins, ins_len and ins_pc read 0.
- pred_on is sampled combinationally. Changing it while bytes are buffered is illegal: the core flushes first.

Optional Feature:
- Macro FT64_ALIGN_DCI_EN.
- Defined: if b[5:0]==CMPRSSD_OP, length is 2|pred_on, overriding the b[7:6] rule.
- Undefined: the b[7:6] rule applies to all bytes and CMPRSSD_OP is ignored.

Test Plan:
- Reset, then one beat containing lengths 4,6,2 from PC 0x1000, pred_on=0, dec_ready=1.
  - Cycle 1: lanes 0/1 valid, len 4/6, pc 0x1000/0x1004.
  - Next cycle: lane 0 len 2, pc 0x100A.
- pred_on=1, first bytes 0x00,0x40,0x80.
  - ins_len = 5,7,3; offsets 0,5,12.
  - ins bytes beyond each length are zero.
- 6-byte instruction starting at buffer byte 14 of a 16-byte beat.
  - Lane invalid until the next beat is accepted, then valid with pc 0x100E and all bytes correct.
- dec_ready=0 with continuous fetch_valid.
  - fetch_ready drops when count reaches 32.
  - No overwrite; consume resumes in order.
- Flush with flush_pc=0x2000 asserted in the same cycle as consume and accept.
  - Next cycle: count=0, ins_valid=0.
  - The next beat decodes from pc 0x2000.
- With FT64_ALIGN_DCI_EN, byte 0xED (b[7:6]=11, b[5:0]=0x2D) gives len 2; byte 0x2D (b[7:6]=00) gives len 2.
  - Without the macro, 0x2D gives len 4.
- rst_n low mid-stream: all outputs zero next cycle; fetch_ready=1 one cycle after release.

Source files
------------

// File: rtl/ft64_ins_aligner.sv
// ft64_ins_aligner: buffers raw I-cache fetch bytes and presents up to LANES
// length-decoded FT64 instructions per cycle, each with its PC.
// Optional build macro FT64_ALIGN_DCI_EN: decode the compressed format
// (byte0[5:0] == CMPRSSD_OP) as a 2-byte instruction.
module ft64_ins_aligner #(
    parameter int         FETCH_BYTES = 16,
    parameter int         BUF_BYTES   = 32,
    parameter int         LANES       = 2,
    parameter int         PCW         = 32,
    parameter logic [5:0] CMPRSSD_OP  = 6'h2D
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pred_on,
    input  logic                     flush,
    input  logic [PCW-1:0]           flush_pc,
    input  logic                     fetch_valid,
    input  logic [FETCH_BYTES*8-1:0] fetch_data,
    output logic                     fetch_ready,
    output logic [LANES-1:0]         ins_valid,
    output logic [LANES*56-1:0]      ins,
    output logic [LANES*3-1:0]       ins_len,
    output logic [LANES*PCW-1:0]     ins_pc,
    input  logic                     dec_ready
);
    localparam int CW = $clog2(BUF_BYTES + 1);

    logic [BUF_BYTES*8-1:0] buf_q, buf_d;
    logic [CW-1:0]          count_q, count_d;
    logic [PCW-1:0]         head_pc_q, head_pc_d;
    int                     take;
    logic                   accept;

    // Instruction length from its first byte; the predicate byte adds one.
    function automatic logic [2:0] len_f(input logic [7:0] b, input logic p);
        logic [2:0] l;
        logic       dci;
`ifdef FT64_ALIGN_DCI_EN
        dci = (b[5:0] == CMPRSSD_OP);
`else
        // Compressed format compiled out: the opcode compare is masked off.
        dci = 1'b0 & (b[5:0] == CMPRSSD_OP);
`endif
        if (dci) begin
            l = 3'd2;
        end else begin
            case (b[7:6])
                2'b00:   l = 3'd4;
                2'b01:   l = 3'd6;
                default: l = 3'd2;
            endcase
        end
        return l | {2'b00, p};
    endfunction

    // Byte read from the buffer; indices past the end read as zero.
    function automatic logic [7:0] byte_at(input logic [BUF_BYTES*8-1:0] b, input int idx);
        logic [7:0] r;
        r = 8'h00;
        if (idx >= 0 && idx < BUF_BYTES) r = b[idx*8 +: 8];
        return r;
    endfunction

    // Space for a whole beat, judged on the registered count; never during flush or reset.
    always_comb begin
        fetch_ready = rst_n & ~flush & ((int'(count_q) + FETCH_BYTES) <= BUF_BYTES);
        accept      = fetch_valid & fetch_ready;
    end

    // Walk the buffer from the head, sizing and validating each lane in turn.
    always_comb begin
        int         off;
        logic [2:0] len;
        logic       prev_ok;
        logic       ok;
        ins_valid = '0;
        ins       = '0;
        ins_len   = '0;
        ins_pc    = '0;
        take      = 0;
        off       = 0;
        prev_ok   = 1'b1;
        for (int k = 0; k < LANES; k++) begin
            len = len_f(byte_at(buf_q, off), pred_on);
            ok  = prev_ok && ((off + int'(len)) <= int'(count_q));
            if (ok) begin
                ins_valid[k]          = 1'b1;
                ins_len[k*3 +: 3]     = len;
                ins_pc[k*PCW +: PCW]  = head_pc_q + PCW'(off);
                for (int j = 0; j < 7; j++) begin
                    if (j < int'(len)) ins[k*56 + j*8 +: 8] = byte_at(buf_q, off + j);
                end
                if (dec_ready) take = take + int'(len);
            end
            prev_ok = ok;
            off     = off + int'(len);
        end
    end

    // Shift out consumed bytes, append an accepted beat behind the survivors, or restart on flush.
    always_comb begin
        int base;
        base      = int'(count_q) - take;
        buf_d     = '0;
        for (int i = 0; i < BUF_BYTES; i++) begin
            if (i < base) begin
                buf_d[i*8 +: 8] = byte_at(buf_q, i + take);
            end else if (accept && ((i - base) < FETCH_BYTES)) begin
                buf_d[i*8 +: 8] = fetch_data[(i - base)*8 +: 8];
            end
        end
        count_d   = CW'(base + (accept ? FETCH_BYTES : 0));
        head_pc_d = head_pc_q + PCW'(take);
        if (flush) begin
            buf_d     = '0;
            count_d   = '0;
            head_pc_d = flush_pc;
        end
    end

    // State register; reset clears the byte buffer along with count and PC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_q     <= '0;
            count_q   <= '0;
            head_pc_q <= '0;
        end else begin
            buf_q     <= buf_d;
            count_q   <= count_d;
            head_pc_q <= head_pc_d;
        end
    end
endmodule

// File: tb/tb_ft64_ins_aligner.sv
// Directed bench for ft64_ins_aligner (FETCH_BYTES=16, BUF_BYTES=32, LANES=2, PCW=32).
module tb_ft64_ins_aligner;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         pred_on;
    logic         flush;
    logic [31:0]  flush_pc;
    logic         fetch_valid;
    logic [127:0] fetch_data;
    logic         fetch_ready;
    logic [1:0]   ins_valid;
    logic [111:0] ins;
    logic [5:0]   ins_len;
    logic [63:0]  ins_pc;
    logic         dec_ready;

    logic [127:0] beat;
    int           n_chk  = 0;
    int           n_pass = 0;

    always #5 clk = ~clk;

    ft64_ins_aligner dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pred_on     (pred_on),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .fetch_ready (fetch_ready),
        .ins_valid   (ins_valid),
        .ins         (ins),
        .ins_len     (ins_len),
        .ins_pc      (ins_pc),
        .dec_ready   (dec_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [55:0] lane_ins(input int k);
        return ins[k*56 +: 56];
    endfunction

    function automatic logic [2:0] lane_len(input int k);
        return ins_len[k*3 +: 3];
    endfunction

    function automatic logic [31:0] lane_pc(input int k);
        return ins_pc[k*32 +: 32];
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] exp_ins;
        rst_n = 1'b0; pred_on = 1'b0; flush = 1'b0; flush_pc = '0;
        fetch_valid = 1'b0; fetch_data = '0; dec_ready = 1'b0;
        tick(); tick();
        #1;
        check("rst_valid", 64'(ins_valid), 64'h0);
        check("rst_ready", 64'(fetch_ready), 64'h0);
        check("rst_ins0", 64'(lane_ins(0)), 64'h0);
        check("rst_ins1", 64'(lane_ins(1)), 64'h0);
        check("rst_len", 64'(ins_len), 64'h0);
        check("rst_pc", ins_pc, 64'h0);

        // Basic 4/6/2 stream from 0x1000
        rst_n = 1'b1; flush = 1'b1; flush_pc = 32'h1000;
        #1;
        check("flush_ready_low", 64'(fetch_ready), 64'h0);
        tick();
        flush = 1'b0;
        beat = 128'h33_80_32_C0_31_81_25_24_23_22_21_41_13_12_11_00;
        fetch_data = beat; fetch_valid = 1'b1; dec_ready = 1'b1;
        #1;
        check("b1_ready", 64'(fetch_ready), 64'h1);
        check("b1_empty", 64'(ins_valid), 64'h0);
        tick();
        fetch_valid = 1'b0;
        #1;
        check("b1_c1_valid", 64'(ins_valid), 64'h3);
        check("b1_c1_len0", 64'(lane_len(0)), 64'd4);
        check("b1_c1_pc0", 64'(lane_pc(0)), 64'h1000);
        check("b1_c1_ins0", 64'(lane_ins(0)), 64'h13121100);
        check("b1_c1_len1", 64'(lane_len(1)), 64'd6);
        check("b1_c1_pc1", 64'(lane_pc(1)), 64'h1004);
        check("b1_c1_ins1", 64'(lane_ins(1)), 64'h252423222141);
        tick();
        #1;
        check("b1_c2_valid", 64'(ins_valid), 64'h3);
        check("b1_c2_len0", 64'(lane_len(0)), 64'd2);
        check("b1_c2_pc0", 64'(lane_pc(0)), 64'h100A);
        check("b1_c2_ins0", 64'(lane_ins(0)), 64'h3181);
        check("b1_c2_pc1", 64'(lane_pc(1)), 64'h100C);
        check("b1_c2_ins1", 64'(lane_ins(1)), 64'h32C0);
        tick();
        #1;
        check("b1_c3_valid", 64'(ins_valid), 64'h1);
        check("b1_c3_pc0", 64'(lane_pc(0)), 64'h100E);
        check("b1_c3_ins0", 64'(lane_ins(0)), 64'h3380);
        check("b1_c3_ins1_zero", 64'(lane_ins(1)), 64'h0);
        tick();
        #1;
        check("b1_drained", 64'(ins_valid), 64'h0);

        // Predicate byte present: lengths 5/7/3
        dec_ready = 1'b0; flush = 1'b1; flush_pc = 32'h3000; pred_on = 1'b1;
        tick();
        flush = 1'b0;
        beat = 128'hFF_82_81_80_46_45_44_43_42_41_40_04_03_02_01_00;
        fetch_data = beat; fetch_valid = 1'b1;
        tick();
        fetch_valid = 1'b0;
        #1;
        check("pred_valid", 64'(ins_valid), 64'h3);
        check("pred_len0", 64'(lane_len(0)), 64'd5);
        check("pred_len1", 64'(lane_len(1)), 64'd7);
        check("pred_pc1", 64'(lane_pc(1)), 64'h3005);
        check("pred_ins0", 64'(lane_ins(0)), 64'h0403020100);
        check("pred_ins1", 64'(lane_ins(1)), 64'h46454443424140);
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        #1;
        check("pred_c2_valid", 64'(ins_valid), 64'h1);
        check("pred_c2_len0", 64'(lane_len(0)), 64'd3);
        check("pred_c2_pc0", 64'(lane_pc(0)), 64'h300C);
        check("pred_c2_ins0", 64'(lane_ins(0)), 64'h828180);
        flush = 1'b1; flush_pc = 32'h1000; pred_on = 1'b0;
        tick();
        flush = 1'b0;

        // 6-byte instruction straddling two beats
        beat = '0;
        for (int m = 0; m < 7; m++) begin
            beat[(2*m)*8 +: 8]   = 8'h80;
            beat[(2*m+1)*8 +: 8] = 8'(8'h50 + m);
        end
        beat[14*8 +: 8] = 8'h41;
        beat[15*8 +: 8] = 8'hA1;
        fetch_data = beat; fetch_valid = 1'b1;
        tick();
        fetch_valid = 1'b0; dec_ready = 1'b1;
        tick(); tick(); tick();
        #1;
        check("split_pre_valid", 64'(ins_valid), 64'h1);
        check("split_pre_pc0", 64'(lane_pc(0)), 64'h100C);
        tick();
        #1;
        check("split_held", 64'(ins_valid), 64'h0);
        check("split_ready", 64'(fetch_ready), 64'h1);
        dec_ready = 1'b0;
        beat = '0;
        beat[31:0] = 32'hA5A4A3A2;
        for (int m = 0; m < 6; m++) begin
            beat[(4+2*m)*8 +: 8] = 8'h80;
            beat[(5+2*m)*8 +: 8] = 8'(8'h60 + m);
        end
        fetch_data = beat; fetch_valid = 1'b1;
        tick();
        fetch_valid = 1'b0;
        #1;
        check("split_valid", 64'(ins_valid), 64'h3);
        check("split_len0", 64'(lane_len(0)), 64'd6);
        check("split_pc0", 64'(lane_pc(0)), 64'h100E);
        check("split_ins0", 64'(lane_ins(0)), 64'hA5A4A3A2A141);
        check("split_pc1", 64'(lane_pc(1)), 64'h1014);
        check("split_ins1", 64'(lane_ins(1)), 64'h6080);
        flush = 1'b1; flush_pc = 32'h4000;
        tick();
        flush = 1'b0;

        // Fill to capacity with the decoder stalled
        beat = '0;
        for (int m = 0; m < 8; m++) begin
            beat[(2*m)*8 +: 8]   = 8'h80;
            beat[(2*m+1)*8 +: 8] = 8'(m);
        end
        fetch_data = beat; fetch_valid = 1'b1;
        #1;
        check("full_rdy_a", 64'(fetch_ready), 64'h1);
        tick();
        for (int m = 0; m < 8; m++) begin
            beat[(2*m)*8 +: 8]   = 8'hB0;
            beat[(2*m+1)*8 +: 8] = 8'(8 + m);
        end
        fetch_data = beat;
        #1;
        check("full_rdy_b", 64'(fetch_ready), 64'h1);
        tick();
        fetch_data = {128{1'b1}};
        #1;
        check("full_rdy_low", 64'(fetch_ready), 64'h0);
        tick();
        #1;
        check("full_hold_rdy", 64'(fetch_ready), 64'h0);
        check("full_hold_ins0", 64'(lane_ins(0)), 64'h0080);
        check("full_hold_pc0", 64'(lane_pc(0)), 64'h4000);
        fetch_valid = 1'b0; dec_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            exp_ins = (2*c < 8) ? 64'({8'(2*c), 8'h80}) : 64'({8'(2*c), 8'hB0});
            check($sformatf("full_ins0_%0d", c), 64'(lane_ins(0)), exp_ins);
            exp_ins = (2*c+1 < 8) ? 64'({8'(2*c+1), 8'h80}) : 64'({8'(2*c+1), 8'hB0});
            check($sformatf("full_ins1_%0d", c), 64'(lane_ins(1)), exp_ins);
            check($sformatf("full_pc0_%0d", c), 64'(lane_pc(0)), 64'(32'h4000 + 4*c));
            tick();
        end
        dec_ready = 1'b0;
        #1;
        check("full_drained", 64'(ins_valid), 64'h0);

        // Flush concurrent with consume and accept
        for (int m = 0; m < 8; m++) begin
            beat[(2*m)*8 +: 8]   = 8'h80;
            beat[(2*m+1)*8 +: 8] = 8'(8'h70 + m);
        end
        fetch_data = beat; fetch_valid = 1'b1;
        tick();
        dec_ready = 1'b1; flush = 1'b1; flush_pc = 32'h2000;
        #1;
        check("fl_ready_low", 64'(fetch_ready), 64'h0);
        check("fl_pre_valid", 64'(ins_valid), 64'h3);
        tick();
        flush = 1'b0; fetch_valid = 1'b0; dec_ready = 1'b0;
        #1;
        check("fl_valid", 64'(ins_valid), 64'h0);
        check("fl_ready", 64'(fetch_ready), 64'h1);
        beat = '0;
        beat[47:0] = 48'h09_C1_08_07_06_05;
        fetch_data = beat; fetch_valid = 1'b1;
        tick();
        fetch_valid = 1'b0;
        #1;
        check("fl_pc0", 64'(lane_pc(0)), 64'h2000);
        check("fl_len0", 64'(lane_len(0)), 64'd4);
        check("fl_ins0", 64'(lane_ins(0)), 64'h08070605);
        check("fl_pc1", 64'(lane_pc(1)), 64'h2004);
        check("fl_ins1", 64'(lane_ins(1)), 64'h09C1);

        // Compressed-format opcode
        flush = 1'b1; flush_pc = 32'h6000;
        tick();
        flush = 1'b0;
        beat = '0;
        beat[47:0] = 48'h13_ED_12_ED_11_2D;
        fetch_data = beat; fetch_valid = 1'b1;
        tick();
        fetch_valid = 1'b0;
        #1;
        check("dci_len1", 64'(lane_len(1)), 64'd2);
`ifdef FT64_ALIGN_DCI_EN
        check("dci_len0", 64'(lane_len(0)), 64'd2);
        check("dci_ins0", 64'(lane_ins(0)), 64'h112D);
        check("dci_pc1", 64'(lane_pc(1)), 64'h6002);
        check("dci_ins1", 64'(lane_ins(1)), 64'h12ED);
`else
        check("dci_len0", 64'(lane_len(0)), 64'd4);
        check("dci_ins0", 64'(lane_ins(0)), 64'h12ED112D);
        check("dci_pc1", 64'(lane_pc(1)), 64'h6004);
        check("dci_ins1", 64'(lane_ins(1)), 64'h13ED);
`endif

        // Reset with bytes buffered
        rst_n = 1'b0;
        #1;
        check("mrst_ready_low", 64'(fetch_ready), 64'h0);
        tick();
        #1;
        check("mrst_valid", 64'(ins_valid), 64'h0);
        check("mrst_ins0", 64'(lane_ins(0)), 64'h0);
        check("mrst_ins1", 64'(lane_ins(1)), 64'h0);
        check("mrst_len", 64'(ins_len), 64'h0);
        check("mrst_pc", ins_pc, 64'h0);
        rst_n = 1'b1;
        tick();
        #1;
        check("mrst_ready_rel", 64'(fetch_ready), 64'h1);
        check("mrst_valid_rel", 64'(ins_valid), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
